ram_arbiter: RTL and testbench

//   Shares the single-port 128 KiB SPRAM (32-bit words, 15-bit word address) between an instruction-fetch port (A, read-only) and a load/store port (B).
//   - Arbitrates round-robin or fixed priority between the two ports.
//   - Performs read-modify-write for partial-word stores: the RAM write mask is fixed at full word.
//   - Holds the RAM bank bit stable for the read-response cycle, because RAM dataOut is muxed by the current address[14].

---
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port SPRAM (32-bit words) between an instruction-fetch
//   read port (A) and a load/store port (B). Partial-word stores are done as a
//   read-modify-write because the RAM only writes whole words. The bank bit of
//   the RAM address is held for the cycle after every read, because the RAM
//   selects its dataOut by the current address MSB.
//
// Ports
//   clock, resetN            single rising-edge clock, synchronous active-low reset
//   aValid/aAddress/aReady   port A read request handshake
//   aRespValid/aRdata        port A read response (one-cycle pulse, data held after)
//   bValid/bWrite/bStrobe/
//   bAddress/bWdata/bReady   port B load/store request handshake
//   bRespValid/bRdata        port B response (load data, or 0 for a store)
//   ramWriteEnable/ramAddress/
//   ramDataIn/ramDataOut     SPRAM interface; dataOut is valid the cycle after a read
module ram_arbiter #(
  parameter int ADDR_WIDTH     = 15,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  aValid,
  input  logic [ADDR_WIDTH-1:0] aAddress,
  output logic                  aReady,
  output logic                  aRespValid,
  output logic [31:0]           aRdata,
  input  logic                  bValid,
  input  logic                  bWrite,
  input  logic [3:0]            bStrobe,
  input  logic [ADDR_WIDTH-1:0] bAddress,
  input  logic [31:0]           bWdata,
  output logic                  bReady,
  output logic                  bRespValid,
  output logic [31:0]           bRdata,
  output logic                  ramWriteEnable,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [31:0]           ramDataIn,
  input  logic [31:0]           ramDataOut
);

  localparam int BANK = ADDR_WIDTH - 1;

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } stateType;

  stateType              state;
  stateType              nextState;
  logic                  rrPointerB;   // 1: B wins the next tie
  logic                  readPending;  // previous cycle was a RAM read
  logic                  pendingBank;  // bank of that read
  logic [ADDR_WIDTH-1:0] lastAddress;
  logic                  aRespValidQ;
  logic                  bRespValidQ;
  logic                  bRespIsLoad;
  logic [31:0]           aRdataHold;
  logic [31:0]           bRdataHold;
  logic [ADDR_WIDTH-1:0] rmwAddress;
  logic [31:0]           rmwData;
  logic [3:0]            rmwStrobe;

  logic pickA;
  logic pickB;
  logic winnerBank;
  logic bankOk;
  logic grantA;
  logic grantB;
  logic bFullStore;
  logic bPartialStore;

  assign bFullStore    = bWrite && (bStrobe == 4'hF);
  assign bPartialStore = bWrite && (bStrobe != 4'hF) && (bStrobe != 4'h0);

  // Arbitration picks a winner first; the bank hold then either lets that
  // winner through or stalls both ports, so a blocked winner retries next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    pickA = 1'b0;
    pickB = 1'b0;
    if (state == IDLE) begin
      if (aValid && bValid) begin
        if (FIXED_PRIORITY || rrPointerB) pickB = 1'b1;
        else                              pickA = 1'b1;
      end else begin
        pickA = aValid;
        pickB = bValid;
      end
    end
  end

  assign winnerBank = pickB ? bAddress[BANK] : aAddress[BANK];
  assign bankOk     = !readPending || (winnerBank == pendingBank);
  assign grantA     = resetN && pickA && bankOk;
  assign grantB     = resetN && pickB && bankOk;

  // RAM drive: the RMW write owns the RAM, otherwise the granted port, otherwise
  // the address is held so the bank mux inside the RAM does not move.
  always_comb begin
    ramWriteEnable = 1'b0;
    ramAddress     = lastAddress;
    ramDataIn      = '0;
    if (state == RMW_WRITE) begin
      ramWriteEnable = 1'b1;
      ramAddress     = rmwAddress;
      for (int i = 0; i < 4; i++) begin
        ramDataIn[8*i +: 8] = rmwStrobe[i] ? rmwData[8*i +: 8] : ramDataOut[8*i +: 8];
      end
    end else if (grantA) begin
      ramAddress = aAddress;
    end else if (grantB) begin
      ramAddress = bAddress;
      if (bFullStore) begin
        ramWriteEnable = 1'b1;
        ramDataIn      = bWdata;
      end
    end
    // Reset wins combinationally so an in-flight RMW can never write.
    if (!resetN) begin
      ramWriteEnable = 1'b0;
      ramAddress     = '0;
      ramDataIn      = '0;
    end
  end

  always_comb begin
    nextState = IDLE;
    if (state == IDLE && grantB && bPartialStore) nextState = RMW_WRITE;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (!resetN) begin
      state       <= IDLE;
      rrPointerB  <= 1'b0;
      readPending <= 1'b0;
      pendingBank <= 1'b0;
      lastAddress <= '0;
      aRespValidQ <= 1'b0;
      bRespValidQ <= 1'b0;
      bRespIsLoad <= 1'b0;
      aRdataHold  <= '0;
      bRdataHold  <= '0;
    end else begin
      state       <= nextState;
      lastAddress <= ramAddress;
      if (grantA || grantB) rrPointerB <= grantA;
      readPending <= grantA || (grantB && !bWrite) || (grantB && bPartialStore);
      pendingBank <= ramAddress[BANK];
      aRespValidQ <= grantA;
      bRespValidQ <= (grantB && !bPartialStore) || (state == RMW_WRITE);
      bRespIsLoad <= grantB && !bWrite;
      if (aRespValidQ) aRdataHold <= ramDataOut;
      if (bRespValidQ) bRdataHold <= bRespIsLoad ? ramDataOut : 32'h0;
    end
  end

  // NOTE: the RMW payload is only consumed in RMW_WRITE, which is always
  // entered through a capture, so these registers carry no reset.
  always_ff @(posedge clock) begin
    if (grantB && bPartialStore) begin
      rmwAddress <= bAddress;
      rmwData    <= bWdata;
      rmwStrobe  <= bStrobe;
    end
  end

  assign aReady     = grantA;
  assign bReady     = grantB;
  assign aRespValid = resetN && aRespValidQ;
  assign bRespValid = resetN && bRespValidQ;
  assign aRdata     = !resetN ? 32'h0 : (aRespValidQ ? ramDataOut : aRdataHold);
  assign bRdata     = !resetN ? 32'h0 :
                      (bRespValidQ ? (bRespIsLoad ? ramDataOut : 32'h0) : bRdataHold);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        resetN;
  logic        aValid, bValid, bWrite;
  logic [14:0] aAddress, bAddress;
  logic [3:0]  bStrobe;
  logic [31:0] bWdata;

  logic        aReady, aRespValid, bReady, bRespValid, ramWriteEnable;
  logic [31:0] aRdata, bRdata, ramDataIn, ramDataOut;
  logic [14:0] ramAddress;

  // Second instance with fixed priority shares all request inputs.
  logic        pAReady, pARespValid, pBReady, pBRespValid, pRamWriteEnable;
  logic [31:0] pARdata, pBRdata, pRamDataIn;
  logic [31:0] pRamDataOut = 32'h0;
  logic [14:0] pRamAddress;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_WIDTH(15), .FIXED_PRIORITY(1'b0)) dut (
    .clock(clock), .resetN(resetN),
    .aValid(aValid), .aAddress(aAddress), .aReady(aReady),
    .aRespValid(aRespValid), .aRdata(aRdata),
    .bValid(bValid), .bWrite(bWrite), .bStrobe(bStrobe), .bAddress(bAddress),
    .bWdata(bWdata), .bReady(bReady), .bRespValid(bRespValid), .bRdata(bRdata),
    .ramWriteEnable(ramWriteEnable), .ramAddress(ramAddress),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  ram_arbiter #(.ADDR_WIDTH(15), .FIXED_PRIORITY(1'b1)) dutFixed (
    .clock(clock), .resetN(resetN),
    .aValid(aValid), .aAddress(aAddress), .aReady(pAReady),
    .aRespValid(pARespValid), .aRdata(pARdata),
    .bValid(bValid), .bWrite(bWrite), .bStrobe(bStrobe), .bAddress(bAddress),
    .bWdata(bWdata), .bReady(pBReady), .bRespValid(pBRespValid), .bRdata(pBRdata),
    .ramWriteEnable(pRamWriteEnable), .ramAddress(pRamAddress),
    .ramDataIn(pRamDataIn), .ramDataOut(pRamDataOut)
  );

  // SPRAM model: two banks, each registering its last read; dataOut is muxed
  // by the current address MSB, so a bank change during a response corrupts it.
  logic [31:0] ram [0:32767];
  logic [31:0] bankOut [2];
  logic        preEn = 1'b0;
  logic [14:0] preAddr = '0;
  logic [31:0] preData = '0;

  always @(posedge clock) begin
    if (preEn) ram[preAddr] <= preData;
    else if (ramWriteEnable) ram[ramAddress] <= ramDataIn;
    bankOut[ramAddress[14]] <= ram[ramAddress];
  end
  assign ramDataOut = bankOut[ramAddress[14]];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic preload(input logic [14:0] addr, input logic [31:0] data);
    preEn = 1'b1; preAddr = addr; preData = data;
    tick();
    preEn = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " ready"}, {aReady, bReady}, 2'b00);
    check({tag, " resp"}, {aRespValid, bRespValid}, 2'b00);
    check({tag, " rdata"}, aRdata | bRdata, 32'h0);
    check({tag, " ram"}, {16'h0, ramWriteEnable, ramAddress} | ramDataIn, 32'h0);
  endtask

  // Reference model state for the random phase.
  logic [31:0] shadow [0:32767];
  logic        aDue [4];
  logic        bDue [4];
  logic [31:0] aDueData [4];
  logic [31:0] bDueData [4];
  logic        busyAt [4];
  logic        pendAt [4];
  logic        pendBankAt [4];
  logic        lastWinnerB;

  function automatic logic [14:0] randAddr();
    return 15'($urandom_range(0, 1) * 16384 + $urandom_range(0, 15));
  endfunction

  initial begin
    logic [1:0]  g;
    logic [31:0] v;
    logic        expA, expB, winA, winB, winBank, aGot, bGot;
    int          s0, s1, s2;

    resetN = 1'b0;
    aValid = 1'b1; aAddress = '0;
    bValid = 1'b1; bWrite = 1'b0; bStrobe = 4'h0; bAddress = '0; bWdata = '0;

    // 1. Reset with both requesters valid.
    settle();
    checkAllZero("reset1");
    tick();
    checkAllZero("reset2");
    resetN = 1'b1;
    settle();
    check("release grant", {aReady, bReady}, 2'b10);
    tick();
    aValid = 1'b0; bValid = 1'b0;

    preload(15'h0010, 32'hDEADBEEF);
    preload(15'h0020, 32'h11223344);
    preload(15'h0005, 32'h05050505);
    preload(15'h4005, 32'h40054005);
    preload(15'h0030, 32'hCAFEF00D);

    // 2. Simple read.
    aValid = 1'b1; aAddress = 15'h0010;
    settle();
    check("read ready", aReady, 1'b1);
    check("read ramAddress", ramAddress, 15'h0010);
    tick();
    aValid = 1'b0;
    settle();
    check("read respValid", aRespValid, 1'b1);
    check("read rdata", aRdata, 32'hDEADBEEF);

    // 3. Contention; a B load first leaves the pointer at A.
    tick();
    bValid = 1'b1; bWrite = 1'b0; bAddress = 15'h0011;
    settle();
    check("preload B grant", bReady, 1'b1);
    tick();
    bValid = 1'b0;
    tick();
    aValid = 1'b1; aAddress = 15'h0012;
    bValid = 1'b1; bAddress = 15'h0013;
    for (int k = 0; k < 4; k++) begin
      settle();
      g = (k % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("rr grant %0d", k), {aReady, bReady}, g);
      check($sformatf("fixed grant %0d", k), {pAReady, pBReady}, 2'b01);
      tick();
    end
    aValid = 1'b0; bValid = 1'b0;
    tick();

    // 4. Partial store merge; A is blocked during the write cycle.
    bValid = 1'b1; bWrite = 1'b1; bStrobe = 4'b0101;
    bAddress = 15'h0020; bWdata = 32'hAABBCCDD;
    settle();
    check("rmw accept", bReady, 1'b1);
    check("rmw read we", ramWriteEnable, 1'b0);
    check("rmw read addr", ramAddress, 15'h0020);
    tick();
    bValid = 1'b0; aValid = 1'b1; aAddress = 15'h0021;
    settle();
    check("rmw A blocked", aReady, 1'b0);
    check("rmw write we", ramWriteEnable, 1'b1);
    check("rmw write addr", ramAddress, 15'h0020);
    check("rmw merged data", ramDataIn, 32'h11BB33DD);
    check("rmw no early resp", bRespValid, 1'b0);
    tick();
    settle();
    check("rmw respValid", bRespValid, 1'b1);
    check("rmw rdata", bRdata, 32'h0);
    check("rmw A retry", aReady, 1'b1);
    tick();
    aAddress = 15'h0020;
    settle();
    check("rmw readback ready", aReady, 1'b1);
    tick();
    aValid = 1'b0;
    settle();
    check("rmw readback", aRdata, 32'h11BB33DD);
    tick();

    // 5. Bank hold.
    aValid = 1'b1; aAddress = 15'h0005;
    settle();
    check("hold first ready", aReady, 1'b1);
    tick();
    aAddress = 15'h4005;
    settle();
    check("hold blocked", aReady, 1'b0);
    check("hold ramAddress", ramAddress, 15'h0005);
    check("hold data", aRdata, 32'h05050505);
    tick();
    settle();
    check("hold retry", aReady, 1'b1);
    check("hold retry addr", ramAddress, 15'h4005);
    tick();
    aValid = 1'b0;
    settle();
    check("hold second data", aRdata, 32'h40054005);
    tick();

    // 6. Reset during RMW_WRITE aborts the write.
    bValid = 1'b1; bWrite = 1'b1; bStrobe = 4'b0001;
    bAddress = 15'h0030; bWdata = 32'h0;
    settle();
    check("abort accept", bReady, 1'b1);
    tick();
    bValid = 1'b0; resetN = 1'b0;
    settle();
    check("abort we", ramWriteEnable, 1'b0);
    tick();
    resetN = 1'b1;
    settle();
    check("abort no resp", bRespValid, 1'b0);
    tick();
    aValid = 1'b1; aAddress = 15'h0030;
    settle();
    check("abort read ready", aReady, 1'b1);
    tick();
    aValid = 1'b0;
    settle();
    check("abort old word", aRdata, 32'hCAFEF00D);
    tick();

    // Random phase against a transaction-level model.
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      preload(15'((i / 16) * 16384 + (i % 16)), v);
      shadow[(i / 16) * 16384 + (i % 16)] = v;
    end
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aDue[i] = 1'b0; bDue[i] = 1'b0; busyAt[i] = 1'b0; pendAt[i] = 1'b0;
      pendBankAt[i] = 1'b0; aDueData[i] = '0; bDueData[i] = '0;
    end
    lastWinnerB = 1'b1;
    aGot = 1'b0; bGot = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!aValid || aGot) begin
        aValid   = (cyc < 580) && ($urandom_range(0, 2) != 0);
        aAddress = randAddr();
      end
      if (!bValid || bGot) begin
        bValid   = (cyc < 580) && ($urandom_range(0, 2) != 0);
        bWrite   = 1'($urandom_range(0, 1));
        bAddress = randAddr();
        bWdata   = $urandom;
        case ($urandom_range(0, 3))
          0:       bStrobe = 4'h0;
          1:       bStrobe = 4'hF;
          default: bStrobe = 4'($urandom);
        endcase
      end
      settle();
      s0 = cyc & 3; s1 = (cyc + 1) & 3; s2 = (cyc + 2) & 3;

      check("rand aRespValid", aRespValid, aDue[s0]);
      if (aDue[s0]) check("rand aRdata", aRdata, aDueData[s0]);
      check("rand bRespValid", bRespValid, bDue[s0]);
      if (bDue[s0]) check("rand bRdata", bRdata, bDueData[s0]);
      aDue[s0] = 1'b0; bDue[s0] = 1'b0;

      expA = 1'b0; expB = 1'b0;
      if (!busyAt[s0]) begin
        if (aValid && bValid) begin
          winB = lastWinnerB ? 1'b0 : 1'b1;
          winA = !winB;
        end else begin
          winA = aValid;
          winB = bValid;
        end
        winBank = winB ? bAddress[14] : aAddress[14];
        if (!(pendAt[s0] && winBank != pendBankAt[s0])) begin
          expA = winA; expB = winB;
        end
      end
      busyAt[s0] = 1'b0; pendAt[s0] = 1'b0;
      check("rand aReady", aReady, expA);
      check("rand bReady", bReady, expB);

      if (expA) begin
        lastWinnerB = 1'b0;
        aDue[s1] = 1'b1; aDueData[s1] = shadow[aAddress];
        pendAt[s1] = 1'b1; pendBankAt[s1] = aAddress[14];
      end
      if (expB) begin
        lastWinnerB = 1'b1;
        if (!bWrite) begin
          bDue[s1] = 1'b1; bDueData[s1] = shadow[bAddress];
          pendAt[s1] = 1'b1; pendBankAt[s1] = bAddress[14];
        end else if (bStrobe == 4'hF || bStrobe == 4'h0) begin
          if (bStrobe == 4'hF) shadow[bAddress] = bWdata;
          bDue[s1] = 1'b1; bDueData[s1] = 32'h0;
        end else begin
          v = shadow[bAddress];
          for (int k = 0; k < 4; k++) begin
            if (bStrobe[k]) v[8*k +: 8] = bWdata[8*k +: 8];
          end
          shadow[bAddress] = v;
          bDue[s2] = 1'b1; bDueData[s2] = 32'h0;
          busyAt[s1] = 1'b1;
          pendAt[s1] = 1'b1; pendBankAt[s1] = bAddress[14];
        end
      end
      aGot = expA; bGot = expB;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
